trap_ctrl: RTL and testbench

Parametrised multi-source trap controller for the Mini-RISC-V core, replacing the single-source `trap`/`trapping`/`trigger_trap` logic inside the core top. It accepts a synchronous `ecall` exception plus `NUM_SRC` edge-latched interrupt lines and applies per-source masking and fixed priority. It captures `mepc`/`mcause`, produces the fetch redirect vector, and sequences trap entry and `mret` return with one-cycle pulses toward fetch, decode and CSR.

---
 rtl/trap_ctrl_if.sv | 39 +++
 rtl/trap_ctrl.sv | 153 +++++++++++++++
 tb/tb_trap_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - core-side bus between the pipeline and trap_ctrl
interface trap_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
);
    logic                mem_hold;
    logic [NUM_SRC-1:0]  irq_src;
    logic                ecall;
    logic                trap_ret;
    logic [XLEN-1:0]     epc_in;
    logic [XLEN-1:0]     mtvec;
    logic                mask_we;
    logic [NUM_SRC-1:0]  mask_wdata;
    logic [NUM_SRC-1:0]  pend_clr;

    logic                trapping;
    logic                trigger_trap;
    logic                trigger_trap_ret;
    logic [XLEN-1:0]     trap_vec;
    logic [XLEN-1:0]     mepc;
    logic [XLEN-1:0]     mcause;
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  irq_mask;
    logic                double_fault;

    modport master (
        output mem_hold, irq_src, ecall, trap_ret, epc_in, mtvec,
               mask_we, mask_wdata, pend_clr,
        input  trapping, trigger_trap, trigger_trap_ret, trap_vec,
               mepc, mcause, pending, irq_mask, double_fault
    );

    modport slave (
        input  mem_hold, irq_src, ecall, trap_ret, epc_in, mtvec,
               mask_we, mask_wdata, pend_clr,
        output trapping, trigger_trap, trigger_trap_ret, trap_vec,
               mepc, mcause, pending, irq_mask, double_fault
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - multi-source trap controller (ecall + edge-latched IRQs); TRAP_VECTORED_EN selects vectored redirect
module trap_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
) (
    input  logic         clk,
    input  logic         Rst,
    trap_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_ACTIVE,
        S_RETURN
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] take_clr;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;
    logic [XLEN-1:0]    vec_q;
    logic [XLEN-1:0]    base;
    logic [XLEN-1:0]    cause_nxt;
    logic [XLEN-1:0]    vec_nxt;
    logic               dfault_q;
    logic               sel_found;
    logic [3:0]         sel_idx;
    logic               req;
    logic               take;
    logic               trapping;
    logic               trig;
    logic               trig_ret;

    assign rise     = bus.irq_src & ~irq_q;
    assign eligible = pending_q & mask_q;
    assign req      = bus.ecall | sel_found;
    assign base     = {bus.mtvec[XLEN-1:2], 2'b00};

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        cause_nxt = '0;
        vec_nxt   = base;
        if (bus.ecall) begin
            cause_nxt = XLEN'(11);
        end else begin
            cause_nxt = {1'b1, {(XLEN-5){1'b0}}, sel_idx};
`ifdef TRAP_VECTORED_EN
            vec_nxt   = base + XLEN'({sel_idx, 2'b00});
`else
            vec_nxt   = base;
`endif
        end
    end

    // A pulse is only raised in the cycle its transition is actually taken.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        trapping  = 1'b0;
        trig      = 1'b0;
        trig_ret  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && !bus.mem_hold) begin
                    take      = 1'b1;
                    state_nxt = S_ENTER;
                end
            end
            S_ENTER: begin
                trapping = 1'b1;
                if (!bus.mem_hold) begin
                    trig      = 1'b1;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                trapping = 1'b1;
                if (bus.trap_ret && !bus.mem_hold) begin
                    state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                if (!bus.mem_hold) begin
                    trig_ret  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        take_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            take_clr[i] = take && !bus.ecall && (sel_idx == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state     <= S_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            vec_q     <= '0;
            dfault_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            irq_q     <= bus.irq_src;
            // New edges win over software clear and over the take clear.
            pending_q <= (pending_q & ~bus.pend_clr & ~take_clr) | rise;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
            if (bus.ecall && trapping) begin
                dfault_q <= 1'b1;
            end
            if (take) begin
                mepc_q   <= bus.epc_in;
                mcause_q <= cause_nxt;
                vec_q    <= vec_nxt;
            end
        end
    end

    assign bus.trapping         = trapping;
    assign bus.trigger_trap     = trig;
    assign bus.trigger_trap_ret = trig_ret;
    assign bus.trap_vec         = vec_q;
    assign bus.mepc             = mepc_q;
    assign bus.mcause           = mcause_q;
    assign bus.pending          = pending_q;
    assign bus.irq_mask         = mask_q;
    assign bus.double_fault     = dfault_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;
    logic clk;
    logic Rst;
    int   n_cmp;
    int   n_err;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    trap_ctrl_if #(.NUM_SRC(4), .XLEN(32)) bus ();

    trap_ctrl #(.NUM_SRC(4), .XLEN(32)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ret_seq();
        bus.trap_ret = 1'b1;
        tick();
        bus.trap_ret = 1'b0;
        check("ret_pulse", 32'(bus.trigger_trap_ret), 32'd1);
        check("ret_trapping", 32'(bus.trapping), 32'd0);
        tick();
        check("ret_pulse_end", 32'(bus.trigger_trap_ret), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Rst             = 1'b0;
        bus.mem_hold    = 1'b0;
        bus.irq_src     = '0;
        bus.ecall       = 1'b0;
        bus.trap_ret    = 1'b0;
        bus.epc_in      = 32'h100;
        bus.mtvec       = 32'h200;
        bus.mask_we     = 1'b0;
        bus.mask_wdata  = '0;
        bus.pend_clr    = '0;
        tick();
        tick();
        check("rst_trapping", 32'(bus.trapping), 32'd0);
        check("rst_trig", 32'(bus.trigger_trap), 32'd0);
        check("rst_trig_ret", 32'(bus.trigger_trap_ret), 32'd0);
        check("rst_vec", bus.trap_vec, 32'd0);
        check("rst_mepc", bus.mepc, 32'd0);
        check("rst_mcause", bus.mcause, 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_mask", 32'(bus.irq_mask), 32'd0);
        check("rst_dfault", 32'(bus.double_fault), 32'd0);
        Rst = 1'b1;
        tick();

        // ecall from IDLE
        bus.ecall = 1'b1;
        tick();
        bus.ecall = 1'b0;
        check("ecall_trig", 32'(bus.trigger_trap), 32'd1);
        check("ecall_trapping", 32'(bus.trapping), 32'd1);
        check("ecall_vec", bus.trap_vec, 32'h200);
        check("ecall_mepc", bus.mepc, 32'h100);
        check("ecall_mcause", bus.mcause, 32'd11);
        tick();
        check("ecall_trig_end", 32'(bus.trigger_trap), 32'd0);
        check("ecall_active", 32'(bus.trapping), 32'd1);
        tick();
        tick();
        ret_seq();

        // priority: sources 1 and 2 rise together
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'hF;
        tick();
        bus.mask_we    = 1'b0;
        check("mask_f", 32'(bus.irq_mask), 32'hF);
        bus.epc_in  = 32'h180;
        bus.irq_src = 4'b0110;
        tick();
        check("prio_pend", 32'(bus.pending), 32'h6);
        check("prio_no_trig_yet", 32'(bus.trigger_trap), 32'd0);
        tick();
        check("prio_trig", 32'(bus.trigger_trap), 32'd1);
        check("prio_mcause", bus.mcause, 32'h8000_0001);
        check("prio_pend_left", 32'(bus.pending), 32'h4);
        check("prio_vec", bus.trap_vec, VEC ? 32'h204 : 32'h200);
        check("prio_mepc", bus.mepc, 32'h180);
        tick();
        ret_seq();
        check("prio_idle_gap", 32'(bus.trigger_trap), 32'd0);
        tick();
        check("prio2_trig", 32'(bus.trigger_trap), 32'd1);
        check("prio2_mcause", bus.mcause, 32'h8000_0002);
        check("prio2_vec", bus.trap_vec, VEC ? 32'h208 : 32'h200);
        check("prio2_pend", 32'(bus.pending), 32'h0);
        bus.irq_src = '0;
        tick();
        ret_seq();

        // masking
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'h0;
        tick();
        bus.mask_we    = 1'b0;
        bus.irq_src    = 4'b0001;
        tick();
        tick();
        check("mask_pend", 32'(bus.pending), 32'h1);
        check("mask_no_trap", 32'(bus.trapping), 32'd0);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'h1;
        tick();
        bus.mask_we    = 1'b0;
        check("mask_wr_no_trig", 32'(bus.trigger_trap), 32'd0);
        tick();
        check("mask_trig", 32'(bus.trigger_trap), 32'd1);
        check("mask_mcause", bus.mcause, 32'h8000_0000);
        check("mask_vec", bus.trap_vec, 32'h200);
        bus.irq_src = '0;
        tick();
        ret_seq();

        // hold defers entry
        bus.mem_hold = 1'b1;
        bus.irq_src  = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_no_trig", 32'(bus.trigger_trap), 32'd0);
        end
        check("hold_pend", 32'(bus.pending), 32'h1);
        bus.mem_hold = 1'b0;
        tick();
        check("hold_trig", 32'(bus.trigger_trap), 32'd1);
        tick();
        check("hold_trig_1cyc", 32'(bus.trigger_trap), 32'd0);
        check("hold_active", 32'(bus.trapping), 32'd1);

        // ecall while ACTIVE
        bus.ecall = 1'b1;
        tick();
        bus.ecall = 1'b0;
        check("df_set", 32'(bus.double_fault), 32'd1);
        check("df_mcause", bus.mcause, 32'h8000_0000);
        check("df_no_trig", 32'(bus.trigger_trap), 32'd0);
        check("df_trapping", 32'(bus.trapping), 32'd1);

        // reset mid-handler
        Rst         = 1'b0;
        bus.irq_src = '0;
        tick();
        check("rst2_trapping", 32'(bus.trapping), 32'd0);
        check("rst2_trig_ret", 32'(bus.trigger_trap_ret), 32'd0);
        check("rst2_mepc", bus.mepc, 32'd0);
        check("rst2_mcause", bus.mcause, 32'd0);
        check("rst2_dfault", 32'(bus.double_fault), 32'd0);
        check("rst2_mask", 32'(bus.irq_mask), 32'd0);
        Rst = 1'b1;
        tick();
        check("rst2_no_ret", 32'(bus.trigger_trap_ret), 32'd0);

        // edge and clear on the same source in the same cycle
        bus.irq_src  = 4'b1000;
        bus.pend_clr = 4'b1000;
        tick();
        bus.pend_clr = '0;
        check("setclr_pend", 32'(bus.pending), 32'h8);
        bus.pend_clr = 4'b1000;
        tick();
        bus.pend_clr = '0;
        check("clr_pend", 32'(bus.pending), 32'h0);
        check("clr_no_trap", 32'(bus.trapping), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
